// File: rtl/lieat_wbu_arbiter.sv
// -----------------------------------------------------------------------------
// lieat_wbu_arbiter
//
// Writeback-stage arbiter. Three EXU result channels (com = ALU/branch, lsu,
// muldiv) compete for the single regfile write port. The winner of each cycle
// is registered and presented one cycle later on:
//   - the regfile write port (rf_wen / rf_waddr / rf_wdata), and
//   - the retire strobe (wbck_ena / wbck_op / wbu_dep_rd).
// The IDU dependency tracker uses the retire strobe to free OITF entries.
//
// Configuration macro:
//   LIEAT_WBU_RR_EN  defined   -> round-robin arbitration.
//                                 The pointer advances lsu -> muldiv -> com -> lsu.
//                    undefined -> fixed priority lsu > muldiv > com.
//                                 There is no pointer state in this build.
//
// Register index width comes from the global `REG_IDX macro. It defaults to 5
// when nothing else has defined it.
//
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   <ch>_valid / <ch>_ready      per-channel handshake (ch = com, lsu, muldiv)
//   <ch>_rdwen/<ch>_rd/<ch>_wdata  per-channel writeback payload
//   rf_wen, rf_waddr, rf_wdata   registered regfile write port
//   wbck_ena, wbck_op            registered retire strobe.
//                                wbck_op is one-hot: [0]=com [1]=lsu [2]=muldiv
//   wbu_dep_rd                   rd of the retiring op. It is 0 when idle.
//   arb_state                    arbitration pointer (0=lsu 1=muldiv 2=com).
//                                It is constant 0 in the fixed-priority build.
//
// Handshake: a channel transfers in a cycle where valid & ready are both 1.
// Ready is combinational from the valids and the pointer only. At most one
// ready is high per cycle. Every ready is 0 while reset is high. A source that
// is not granted keeps valid and payload stable. There is no backpressure from
// the regfile, so a grant is offered every cycle that any source is valid.
// -----------------------------------------------------------------------------
`ifndef REG_IDX
`define REG_IDX 5
`endif

module lieat_wbu_arbiter #(
   parameter int XLEN = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                com_valid,
   output logic                com_ready,
   input  logic                com_rdwen,
   input  logic [`REG_IDX-1:0] com_rd,
   input  logic [XLEN-1:0]     com_wdata,
   input  logic                lsu_valid,
   output logic                lsu_ready,
   input  logic                lsu_rdwen,
   input  logic [`REG_IDX-1:0] lsu_rd,
   input  logic [XLEN-1:0]     lsu_wdata,
   input  logic                muldiv_valid,
   output logic                muldiv_ready,
   input  logic                muldiv_rdwen,
   input  logic [`REG_IDX-1:0] muldiv_rd,
   input  logic [XLEN-1:0]     muldiv_wdata,
   output logic                rf_wen,
   output logic [`REG_IDX-1:0] rf_waddr,
   output logic [XLEN-1:0]     rf_wdata,
   output logic                wbck_ena,
   output logic [2:0]          wbck_op,
   output logic [`REG_IDX-1:0] wbu_dep_rd,
   output logic [1:0]          arb_state
);

   localparam logic [1:0] PTR_LSU    = 2'd0;
   localparam logic [1:0] PTR_MULDIV = 2'd1;
   localparam logic [1:0] PTR_COM    = 2'd2;

   // Arbiter choice before the reset mask.
   logic grant_com;
   logic grant_lsu;
   logic grant_muldiv;

   // Transfers actually taking place this cycle (= ready, since a grant implies valid).
   logic xfer_com;
   logic xfer_lsu;
   logic xfer_muldiv;
   logic xfer_any;

`ifdef LIEAT_WBU_RR_EN
   // ---------------------------------------------------------------------------
   // Round-robin pointer: state register / next-state / grant (output) logic
   // ---------------------------------------------------------------------------
   logic [1:0] ptr_q;
   logic [1:0] ptr_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q <= PTR_LSU;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // The pointer moves to the source after the one granted.
   // It holds when nothing is granted.
   always_comb begin
      ptr_d = ptr_q;
      if (xfer_lsu) begin
         ptr_d = PTR_MULDIV;
      end else if (xfer_muldiv) begin
         ptr_d = PTR_COM;
      end else if (xfer_com) begin
         ptr_d = PTR_LSU;
      end
   end

   // The pointed-to source has the highest priority. The other two follow
   // in rotation order. The unused encoding 3 behaves like lsu.
   always_comb begin
      grant_com    = 1'b0;
      grant_lsu    = 1'b0;
      grant_muldiv = 1'b0;
      case (ptr_q)
         PTR_MULDIV: begin
            if (muldiv_valid)   grant_muldiv = 1'b1;
            else if (com_valid) grant_com    = 1'b1;
            else if (lsu_valid) grant_lsu    = 1'b1;
         end
         PTR_COM: begin
            if (com_valid)         grant_com    = 1'b1;
            else if (lsu_valid)    grant_lsu    = 1'b1;
            else if (muldiv_valid) grant_muldiv = 1'b1;
         end
         default: begin
            if (lsu_valid)         grant_lsu    = 1'b1;
            else if (muldiv_valid) grant_muldiv = 1'b1;
            else if (com_valid)    grant_com    = 1'b1;
         end
      endcase
   end

   assign arb_state = ptr_q;
`else
   // ---------------------------------------------------------------------------
   // Fixed priority lsu > muldiv > com. Com can starve while lsu/muldiv stay valid.
   // ---------------------------------------------------------------------------
   always_comb begin
      grant_com    = 1'b0;
      grant_lsu    = 1'b0;
      grant_muldiv = 1'b0;
      if (lsu_valid)         grant_lsu    = 1'b1;
      else if (muldiv_valid) grant_muldiv = 1'b1;
      else if (com_valid)    grant_com    = 1'b1;
   end

   assign arb_state = PTR_LSU;
`endif

   // Reset masks every ready, so a transfer can never happen in the reset cycle.
   assign xfer_com    = grant_com    & ~reset;
   assign xfer_lsu    = grant_lsu    & ~reset;
   assign xfer_muldiv = grant_muldiv & ~reset;
   assign xfer_any    = xfer_com | xfer_lsu | xfer_muldiv;

   assign com_ready    = xfer_com;
   assign lsu_ready    = xfer_lsu;
   assign muldiv_ready = xfer_muldiv;

   // Payload of the granted channel. The grant is one-hot.
   logic                sel_rdwen;
   logic [`REG_IDX-1:0] sel_rd;
   logic [XLEN-1:0]     sel_wdata;

   always_comb begin
      sel_rdwen = com_rdwen;
      sel_rd    = com_rd;
      sel_wdata = com_wdata;
      if (xfer_lsu) begin
         sel_rdwen = lsu_rdwen;
         sel_rd    = lsu_rd;
         sel_wdata = lsu_wdata;
      end else if (xfer_muldiv) begin
         sel_rdwen = muldiv_rdwen;
         sel_rd    = muldiv_rd;
         sel_wdata = muldiv_wdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Registered output stage.
   // On an idle cycle the strobes go low and rf_waddr/rf_wdata hold their values.
   // A write to x0, or an op with no rd, still retires with wbck_ena=1 so its
   // OITF entry is freed, but it does not write the regfile.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         rf_wen     <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         wbck_ena   <= 1'b0;
         wbck_op    <= 3'b000;
         wbu_dep_rd <= '0;
      end else if (xfer_any) begin
         rf_wen     <= sel_rdwen & (sel_rd != '0);
         rf_waddr   <= sel_rd;
         rf_wdata   <= sel_wdata;
         wbck_ena   <= 1'b1;
         wbck_op    <= {xfer_muldiv, xfer_lsu, xfer_com};
         wbu_dep_rd <= sel_rd;
      end else begin
         rf_wen     <= 1'b0;
         wbck_ena   <= 1'b0;
         wbck_op    <= 3'b000;
         wbu_dep_rd <= '0;
      end
   end

endmodule

// File: tb/tb_lieat_wbu_arbiter.sv
`ifndef REG_IDX
`define REG_IDX 5
`endif

module tb_lieat_wbu_arbiter;

   localparam int XLEN = 32;

   logic                clock;
   logic                reset;
   logic                com_valid, com_ready, com_rdwen;
   logic [`REG_IDX-1:0] com_rd;
   logic [XLEN-1:0]     com_wdata;
   logic                lsu_valid, lsu_ready, lsu_rdwen;
   logic [`REG_IDX-1:0] lsu_rd;
   logic [XLEN-1:0]     lsu_wdata;
   logic                muldiv_valid, muldiv_ready, muldiv_rdwen;
   logic [`REG_IDX-1:0] muldiv_rd;
   logic [XLEN-1:0]     muldiv_wdata;
   logic                rf_wen;
   logic [`REG_IDX-1:0] rf_waddr;
   logic [XLEN-1:0]     rf_wdata;
   logic                wbck_ena;
   logic [2:0]          wbck_op;
   logic [`REG_IDX-1:0] wbu_dep_rd;
   logic [1:0]          arb_state;

   int n_cmp = 0;
   int n_err = 0;

   // Output bundle: {rf_wen, rf_waddr, rf_wdata, wbck_ena, wbck_op, wbu_dep_rd}
   logic [46:0] obs_out;
   logic [46:0] exp_out;
   // Ready bundle: {lsu_ready, muldiv_ready, com_ready}
   logic [2:0]  obs_rdy;

   assign obs_out = {rf_wen, rf_waddr, rf_wdata, wbck_ena, wbck_op, wbu_dep_rd};
   assign obs_rdy = {lsu_ready, muldiv_ready, com_ready};

   lieat_wbu_arbiter #(.XLEN(XLEN)) dut (
      .clock        (clock),
      .reset        (reset),
      .com_valid    (com_valid),
      .com_ready    (com_ready),
      .com_rdwen    (com_rdwen),
      .com_rd       (com_rd),
      .com_wdata    (com_wdata),
      .lsu_valid    (lsu_valid),
      .lsu_ready    (lsu_ready),
      .lsu_rdwen    (lsu_rdwen),
      .lsu_rd       (lsu_rd),
      .lsu_wdata    (lsu_wdata),
      .muldiv_valid (muldiv_valid),
      .muldiv_ready (muldiv_ready),
      .muldiv_rdwen (muldiv_rdwen),
      .muldiv_rd    (muldiv_rd),
      .muldiv_wdata (muldiv_wdata),
      .rf_wen       (rf_wen),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .wbck_ena     (wbck_ena),
      .wbck_op      (wbck_op),
      .wbu_dep_rd   (wbu_dep_rd),
      .arb_state    (arb_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   // Move to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      com_valid    = 1'b0; com_rdwen    = 1'b0; com_rd    = '0; com_wdata    = '0;
      lsu_valid    = 1'b0; lsu_rdwen    = 1'b0; lsu_rd    = '0; lsu_wdata    = '0;
      muldiv_valid = 1'b0; muldiv_rdwen = 1'b0; muldiv_rd = '0; muldiv_wdata = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      tick();
      com_valid = 1'b1; lsu_valid = 1'b1; muldiv_valid = 1'b1;
      #1;
      n_cmp++;
      if (obs_rdy !== 3'b000) begin
         n_err++; $display("FAIL reset_ready: got %b want 000", obs_rdy);
      end
      tick();
      exp_out = '0;
      n_cmp++;
      if (obs_out !== exp_out) begin
         n_err++; $display("FAIL reset_out: got %h want %h", obs_out, exp_out);
      end
      n_cmp++;
      if (arb_state !== 2'd0) begin
         n_err++; $display("FAIL reset_ptr: got %0d want 0", arb_state);
      end
      idle();
      reset = 1'b0;
   endtask

   task automatic test_single_com();
      tick();
      com_valid = 1'b1; com_rdwen = 1'b1; com_rd = 5'd5; com_wdata = 32'h1234;
      #1;
      n_cmp++;
      if (obs_rdy !== 3'b001) begin
         n_err++; $display("FAIL single_ready: got %b want 001", obs_rdy);
      end
      tick();
      exp_out = {1'b1, 5'd5, 32'h0000_1234, 1'b1, 3'b001, 5'd5};
      n_cmp++;
      if (obs_out !== exp_out) begin
         n_err++; $display("FAIL single_out: got %h want %h", obs_out, exp_out);
      end
      idle();
      tick();
      exp_out = {1'b0, 5'd5, 32'h0000_1234, 1'b0, 3'b000, 5'd0};
      n_cmp++;
      if (obs_out !== exp_out) begin
         n_err++; $display("FAIL single_idle: got %h want %h", obs_out, exp_out);
      end
   endtask

   task automatic test_x0_nowrite();
      lsu_valid = 1'b1; lsu_rdwen = 1'b1; lsu_rd = 5'd0; lsu_wdata = 32'hAAAA_0001;
      #1;
      n_cmp++;
      if (obs_rdy !== 3'b100) begin
         n_err++; $display("FAIL x0_ready: got %b want 100", obs_rdy);
      end
      tick();
      exp_out = {1'b0, 5'd0, 32'hAAAA_0001, 1'b1, 3'b010, 5'd0};
      n_cmp++;
      if (obs_out !== exp_out) begin
         n_err++; $display("FAIL x0_out: got %h want %h", obs_out, exp_out);
      end
      idle();
      muldiv_valid = 1'b1; muldiv_rdwen = 1'b0; muldiv_rd = 5'd7; muldiv_wdata = 32'hBBBB_0002;
      #1;
      n_cmp++;
      if (obs_rdy !== 3'b010) begin
         n_err++; $display("FAIL nowrite_ready: got %b want 010", obs_rdy);
      end
      tick();
      exp_out = {1'b0, 5'd7, 32'hBBBB_0002, 1'b1, 3'b100, 5'd7};
      n_cmp++;
      if (obs_out !== exp_out) begin
         n_err++; $display("FAIL nowrite_out: got %h want %h", obs_out, exp_out);
      end
      idle();
      tick();
   endtask

   task automatic test_contention();
      do_reset();
      lsu_valid    = 1'b1; lsu_rdwen    = 1'b1; lsu_rd    = 5'd11; lsu_wdata    = 32'h1111_0000;
      muldiv_valid = 1'b1; muldiv_rdwen = 1'b1; muldiv_rd = 5'd12; muldiv_wdata = 32'h2222_0000;
      com_valid    = 1'b1; com_rdwen    = 1'b1; com_rd    = 5'd13; com_wdata    = 32'h3333_0000;
      #1;
      n_cmp++;
      if (obs_rdy !== 3'b100) begin
         n_err++; $display("FAIL cont_ready0: got %b want 100", obs_rdy);
      end
      tick();
      exp_out = {1'b1, 5'd11, 32'h1111_0000, 1'b1, 3'b010, 5'd11};
      n_cmp++;
      if (obs_out !== exp_out) begin
         n_err++; $display("FAIL cont_out0: got %h want %h", obs_out, exp_out);
      end
      lsu_valid = 1'b0;
      #1;
      n_cmp++;
      if (obs_rdy !== 3'b010) begin
         n_err++; $display("FAIL cont_ready1: got %b want 010", obs_rdy);
      end
      tick();
      exp_out = {1'b1, 5'd12, 32'h2222_0000, 1'b1, 3'b100, 5'd12};
      n_cmp++;
      if (obs_out !== exp_out) begin
         n_err++; $display("FAIL cont_out1: got %h want %h", obs_out, exp_out);
      end
      muldiv_valid = 1'b0;
      #1;
      n_cmp++;
      if (obs_rdy !== 3'b001) begin
         n_err++; $display("FAIL cont_ready2: got %b want 001", obs_rdy);
      end
      tick();
      exp_out = {1'b1, 5'd13, 32'h3333_0000, 1'b1, 3'b001, 5'd13};
      n_cmp++;
      if (obs_out !== exp_out) begin
         n_err++; $display("FAIL cont_out2: got %h want %h", obs_out, exp_out);
      end
      idle();
      tick();
   endtask

   // All three sources stay valid for 6 cycles. The expected ready order
   // depends on the arbitration mode.
   task automatic test_arbitration_order();
      logic [2:0] seq [6];
      logic [2:0] exp_op;
      logic [4:0] exp_rd;
`ifdef LIEAT_WBU_RR_EN
      seq = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
`else
      seq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
`endif
      do_reset();
      lsu_valid    = 1'b1; lsu_rdwen    = 1'b1; lsu_rd    = 5'd21; lsu_wdata    = 32'h21;
      muldiv_valid = 1'b1; muldiv_rdwen = 1'b1; muldiv_rd = 5'd22; muldiv_wdata = 32'h22;
      com_valid    = 1'b1; com_rdwen    = 1'b1; com_rd    = 5'd23; com_wdata    = 32'h23;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_cmp++;
         if (obs_rdy !== seq[i]) begin
            n_err++; $display("FAIL arb_ready[%0d]: got %b want %b", i, obs_rdy, seq[i]);
         end
         // seq bit order is {lsu, muldiv, com}; wbck_op bit order is {muldiv, lsu, com}.
         exp_op = {seq[i][1], seq[i][2], seq[i][0]};
         exp_rd = seq[i][2] ? 5'd21 : (seq[i][1] ? 5'd22 : 5'd23);
         tick();
         n_cmp++;
         if ({wbck_ena, wbck_op, rf_waddr} !== {1'b1, exp_op, exp_rd}) begin
            n_err++;
            $display("FAIL arb_out[%0d]: got ena=%b op=%b rd=%0d want ena=1 op=%b rd=%0d",
                     i, wbck_ena, wbck_op, rf_waddr, exp_op, exp_rd);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 4; i++) begin
         com_valid = 1'b1; com_rdwen = 1'b1;
         com_rd    = 5'(i);
         com_wdata = 32'h100 * i;
         #1;
         n_cmp++;
         if (obs_rdy !== 3'b001) begin
            n_err++; $display("FAIL b2b_ready[%0d]: got %b want 001", i, obs_rdy);
         end
         tick();
         exp_out = {1'b1, 5'(i), 32'h100 * i, 1'b1, 3'b001, 5'(i)};
         n_cmp++;
         if (obs_out !== exp_out) begin
            n_err++; $display("FAIL b2b_out[%0d]: got %h want %h", i, obs_out, exp_out);
         end
      end
      idle();
      tick();
      exp_out = {1'b0, 5'd4, 32'h400, 1'b0, 3'b000, 5'd0};
      n_cmp++;
      if (obs_out !== exp_out) begin
         n_err++; $display("FAIL b2b_idle: got %h want %h", obs_out, exp_out);
      end
   endtask

   task automatic test_reset_midflight();
      com_valid = 1'b1; com_rdwen = 1'b1; com_rd = 5'd9; com_wdata = 32'h9999;
      tick();
      exp_out = {1'b1, 5'd9, 32'h9999, 1'b1, 3'b001, 5'd9};
      n_cmp++;
      if (obs_out !== exp_out) begin
         n_err++; $display("FAIL mid_out: got %h want %h", obs_out, exp_out);
      end
      reset = 1'b1;
      com_rd = 5'd10; com_wdata = 32'hA0A0;
      lsu_valid = 1'b1; muldiv_valid = 1'b1;
      #1;
      n_cmp++;
      if (obs_rdy !== 3'b000) begin
         n_err++; $display("FAIL mid_ready_rst: got %b want 000", obs_rdy);
      end
      tick();
      exp_out = '0;
      n_cmp++;
      if (obs_out !== exp_out) begin
         n_err++; $display("FAIL mid_rst_out: got %h want %h", obs_out, exp_out);
      end
      reset = 1'b0;
      lsu_valid = 1'b0; muldiv_valid = 1'b0;
      #1;
      n_cmp++;
      if (obs_rdy !== 3'b001) begin
         n_err++; $display("FAIL mid_ready_post: got %b want 001", obs_rdy);
      end
      tick();
      exp_out = {1'b1, 5'd10, 32'hA0A0, 1'b1, 3'b001, 5'd10};
      n_cmp++;
      if (obs_out !== exp_out) begin
         n_err++; $display("FAIL mid_post_out: got %h want %h", obs_out, exp_out);
      end
      idle();
      tick();
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_single_com();
      test_x0_nowrite();
      test_contention();
      test_arbitration_order();
      test_back_to_back();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
